// File: rtl/al_osc_pkg.sv
// al_osc_pkg: shared types, defaults and helpers for the oscillator clock divider.
package al_osc_pkg;

    // Standby option encodings
    localparam string STDBY_ENABLE  = "ENABLE";
    localparam string STDBY_DISABLE = "DISABLE";

    // Default geometry
    localparam int NUM_CH_DEF = 4;
    localparam int DIV_W_DEF  = 8;
    localparam int WARMUP_DEF = 16;

    // Per-channel divider state
    typedef enum logic [1:0] {
        CH_STOP     = 2'd0,
        CH_RUN_LO   = 2'd1,
        CH_RUN_HI   = 2'd2,
        CH_DRAIN_HI = 2'd3
    } ch_state_e;

    // Width of the channel index; never below one bit so a single-channel build still has a port
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/al_osc_div_ch.sv
// al_osc_div_ch: one divider channel -- half-period counter, pending reload and stop/drain FSM.
module al_osc_div_ch
    import al_osc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             div_clk_o,
    output logic             div_tick_o
);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] hp_eff;
    logic             pv_q, pv_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Next-state: count phases, toggle at cnt==hp, apply reloads only at a fall or while stopped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        hp_eff  = hp_q;

        if (load_i) begin
            pend_d = val_i;
            pv_d   = 1'b1;
        end

        case (state_q)
            CH_STOP: begin
                cnt_d = '0;
                clk_d = 1'b0;
                // A parked channel takes its pending value immediately; a fresh load waits a cycle
                if (pv_q) begin
                    hp_eff = pend_q;
                    hp_d   = pend_q;
                end
                pv_d = load_i;
                // The start cycle already counts as the first cycle of the low phase
                if (run_i) begin
                    if (hp_eff == '0) begin
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                        state_d = CH_RUN_HI;
                    end else begin
                        cnt_d   = DIV_W'(1);
                        state_d = CH_RUN_LO;
                    end
                end
            end
            CH_RUN_LO: begin
                if (!run_i) begin
                    cnt_d   = '0;
                    state_d = CH_STOP;
                end else if (cnt_q == hp_q) begin
                    cnt_d   = '0;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                    state_d = CH_RUN_HI;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                // High phase always completes; run only decides where the fall lands
                if (cnt_q == hp_q) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (load_i) begin
                        hp_d = val_i;
                        pv_d = 1'b0;
                    end else if (pv_q) begin
                        hp_d = pend_q;
                        pv_d = 1'b0;
                    end
                    state_d = run_i ? CH_RUN_LO : CH_STOP;
                end else begin
                    cnt_d   = cnt_q + DIV_W'(1);
                    state_d = run_i ? CH_RUN_HI : CH_DRAIN_HI;
                end
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CH_STOP;
            cnt_q   <= '0;
            hp_q    <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign div_clk_o  = clk_q;
    assign div_tick_o = tick_q;

endmodule

// File: rtl/al_osc_clkgen.sv
// al_osc_clkgen: multi-channel programmable divider with standby, warm-up ready and divide reload.
module al_osc_clkgen
    import al_osc_pkg::*;
#(
    parameter int    NUM_CH = NUM_CH_DEF,
    parameter int    DIV_W  = DIV_W_DEF,
    parameter string STDBY  = STDBY_DISABLE,
    parameter int    WARMUP = WARMUP_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          osc_dis,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic                          div_load,
    input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
    input  logic [DIV_W-1:0]              div_val,
    output logic [NUM_CH-1:0]             div_clk,
    output logic [NUM_CH-1:0]             div_tick,
    output logic                          osc_rdy
);

    localparam int CH_W   = ch_idx_w(NUM_CH);
    localparam int WU_W   = $clog2(WARMUP + 1);
    localparam bit SBY_EN = (STDBY == STDBY_ENABLE);

    logic              sby;
    logic [WU_W-1:0]   wu_q, wu_d;
    logic              rdy_q, rdy_d;
    logic [NUM_CH-1:0] load_vec;

    assign sby = SBY_EN & osc_dis;

    // Warm-up count: held at zero in standby, saturates at WARMUP; ready on the cycle it arrives
    always_comb begin
        wu_d = wu_q;
        if (sby) begin
            wu_d = '0;
        end else if (wu_q != WU_W'(WARMUP)) begin
            wu_d = wu_q + WU_W'(1);
        end
        rdy_d = !sby && (wu_d == WU_W'(WARMUP));
    end

    // Warm-up and ready registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wu_q  <= '0;
            rdy_q <= 1'b0;
        end else begin
            wu_q  <= wu_d;
            rdy_q <= rdy_d;
        end
    end

    // Reload decode: an out-of-range channel index matches no channel and is dropped
    always_comb begin
        load_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_vec[i] = div_load && (div_ch == CH_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        al_osc_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .run_i      (ch_en[i] & rdy_q),
            .load_i     (load_vec[i]),
            .val_i      (div_val),
            .div_clk_o  (div_clk[i]),
            .div_tick_o (div_tick[i])
        );
    end

    assign osc_rdy = rdy_q;

endmodule
